// File: rtl/pair_scheduler_if.sv
// Force-unit and integrator handshake bundle between the pair scheduler (master) and the physics datapath (slave).
interface pair_scheduler_if #(
  parameter int IDX_W = 4
);
  logic             pair_valid;
  logic             pair_ready;
  logic [IDX_W-1:0] pair_a;
  logic [IDX_W-1:0] pair_b;
  logic             pair_done;
  logic             integrate;
  logic             integrate_done;

  modport master (
    output pair_valid, pair_a, pair_b, integrate,
    input  pair_ready, pair_done, integrate_done
  );

  modport slave (
    input  pair_valid, pair_a, pair_b, integrate,
    output pair_ready, pair_done, integrate_done
  );
endinterface

// File: rtl/pair_scheduler.sv
// Per frame, walks all sprite pairs (a<b) through the shared force unit, then fires one integrate pulse; ticks arriving while busy are dropped and flagged.
// Pair_valid holds until pair_ready; optional watchdog on the done pulses under macro PAIR_TIMEOUT_EN.
module pair_scheduler #(
  parameter int SPRITES = 2,
  parameter int IDX_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic            clock_162,
  input  logic            rst_n,
  input  logic            run,
  input  logic            frame_tick,
  pair_scheduler_if.master pif,
  output logic            busy,
  output logic [15:0]     step_count,
  output logic            overrun,
  output logic            timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_INTEG,
    S_INTEG_WAIT
  } state_t;

  localparam logic [IDX_W-1:0] LAST_A = IDX_W'((SPRITES > 1) ? SPRITES - 2 : 0);
  localparam logic [IDX_W-1:0] LAST_B = IDX_W'((SPRITES > 1) ? SPRITES - 1 : 0);

  if (SPRITES < 1 || SPRITES > 16 || IDX_W < 1 || IDX_W < $clog2(SPRITES) || TIMEOUT < 1) begin : g_bad_cfg
    $error("pair_scheduler: illegal parameter combination");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_a;
  logic [IDX_W-1:0] r_b;
  logic [15:0]      r_step_cnt;
  logic             r_overrun;
  logic             w_start;
  logic             w_last_pair;
  logic             w_wd_expire;
  logic             w_pair_fin;
  logic             w_integ_fin;

  assign w_start     = frame_tick && run;
  assign w_last_pair = (r_a == LAST_A) && (r_b == LAST_B);
  assign w_pair_fin  = pif.pair_done || w_wd_expire;
  assign w_integ_fin = pif.integrate_done || w_wd_expire;

`ifdef PAIR_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [WD_W-1:0] r_wd;
  logic            r_timeout;
  logic            w_waiting;

  assign w_waiting   = (r_state == S_WAIT) || (r_state == S_INTEG_WAIT);
  assign w_wd_expire = w_waiting && (r_wd == WD_W'(TIMEOUT - 1));
  assign timeout_err = r_timeout;

  // The counter restarts on every state change, so each pair gets a full budget.
  always_ff @(posedge clock_162 or negedge rst_n) begin
    if (!rst_n) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_state_nxt != r_state) begin
        r_wd <= '0;
      end else if (w_waiting) begin
        r_wd <= r_wd + WD_W'(1);
      end
      if (w_wd_expire &&
          !((r_state == S_WAIT && pif.pair_done) ||
            (r_state == S_INTEG_WAIT && pif.integrate_done))) begin
        r_timeout <= 1'b1;
      end
    end
  end
`else
  assign w_wd_expire = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clock_162 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = (SPRITES == 1) ? S_INTEG : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (pif.pair_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_pair_fin) begin
          w_state_nxt = w_last_pair ? S_INTEG : S_ISSUE;
        end
      end
      S_INTEG: begin
        w_state_nxt = S_INTEG_WAIT;
      end
      S_INTEG_WAIT: begin
        if (w_integ_fin) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    pif.pair_valid = 1'b0;
    pif.integrate  = 1'b0;
    busy           = 1'b1;
    case (r_state)
      S_IDLE:  busy           = 1'b0;
      S_ISSUE: pif.pair_valid = 1'b1;
      S_INTEG: pif.integrate  = 1'b1;
      default: busy           = 1'b1;
    endcase
  end

  // Lexicographic walk: bump b until it hits the last sprite, then restart b just above the new a.
  always_ff @(posedge clock_162 or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
    end else if (r_state == S_IDLE && w_start) begin
      r_a <= '0;
      r_b <= IDX_W'(1);
    end else if (r_state == S_WAIT && w_pair_fin && !w_last_pair) begin
      if (r_b < LAST_B) begin
        r_b <= r_b + IDX_W'(1);
      end else begin
        r_a <= r_a + IDX_W'(1);
        r_b <= r_a + IDX_W'(2);
      end
    end
  end

  assign pif.pair_a = r_a;
  assign pif.pair_b = r_b;

  always_ff @(posedge clock_162 or negedge rst_n) begin
    if (!rst_n) begin
      r_step_cnt <= '0;
      r_overrun  <= 1'b0;
    end else begin
      if (r_state == S_INTEG_WAIT && w_integ_fin) begin
        r_step_cnt <= r_step_cnt + 16'd1;
      end
      if (frame_tick && r_state != S_IDLE) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign step_count = r_step_cnt;
  assign overrun    = r_overrun;

endmodule
